// File: rtl/sdpb_fifo_ctrl.sv
// sdpb_fifo_ctrl: byte-in / word-out FIFO controller for a simple dual-port
// block RAM with a 512x8 write view and a 128x32 read view (bypass mode,
// one-cycle read latency). Bytes are packed little-endian into 32-bit words.
//
// A two-entry output stage (m_data plus one skid word) lets a read be issued
// in the same cycle as a pop even while the previous read is still returning.
// That keeps a steady stream at one word per clock despite the RAM latency.
//
// Optional build macro SDPB_FIFO_LEVEL_EN adds the level[9:0] and need_data
// status outputs.
module sdpb_fifo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        flush,
    output logic        underrun,
    output logic        ram_cea,
    output logic        ram_ceb,
    output logic        ram_oce,
    output logic [8:0]  ram_ada,
    output logic [7:0]  ram_din,
    output logic [6:0]  ram_adb,
    input  logic [31:0] ram_dout
`ifdef SDPB_FIFO_LEVEL_EN
    ,
    output logic [9:0]  level,
    output logic        need_data
`endif
);

    logic [8:0]  wptr;
    logic [6:0]  rptr;
    logic [9:0]  bcnt;
    logic        pending;
    logic        skid_valid;
    logic [31:0] skid_data;
    logic        armed;

    logic        wr;
    logic        pop;
    logic        issue;
    logic        advance;
    logic        out_load;
    logic        skid_load;
    logic [1:0]  committed;
    logic [9:0]  reserved;
    logic        room_ok;
    logic        avail_ok;

    // Handshakes, read-issue decision and RAM port drive.
    always_comb begin
        s_ready   = !bcnt[9] && !flush && !reset;
        wr        = s_valid && s_ready;
        pop       = m_valid && m_ready;

        // Words already taken out of the RAM and not yet popped: the one in
        // m_data, the one in the skid slot and the one still returning.
        committed = {1'b0, m_valid} + {1'b0, skid_valid} + {1'b0, pending};
        reserved  = {6'd0, committed, 2'b00};
        room_ok   = (committed - {1'b0, pop}) < 2'd2;
        avail_ok  = bcnt >= (reserved + 10'd4);
        issue     = room_ok && avail_ok && !flush && !reset;

        // The output register advances when it is empty or being popped.
        advance   = pop || !m_valid;
        out_load  = advance && (skid_valid || pending) && !flush && !reset;
        skid_load = pending && (!advance || skid_valid) && !flush && !reset;

        ram_cea   = wr;
        ram_ada   = wptr;
        ram_din   = s_data;
        ram_ceb   = issue;
        ram_adb   = rptr;
        ram_oce   = 1'b1;

        underrun  = armed && m_ready && !m_valid && !flush && !reset;
    end

    // Control state: pointers, byte count, output-stage occupancy, underrun arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            bcnt       <= '0;
            pending    <= 1'b0;
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
            armed      <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            bcnt       <= '0;
            pending    <= 1'b0;
            m_valid    <= 1'b0;
            skid_valid <= 1'b0;
            armed      <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + 9'd1;
            end
            if (issue) begin
                rptr <= rptr + 7'd1;
            end
            pending <= issue;
            bcnt    <= bcnt + {9'd0, wr} - (pop ? 10'd4 : 10'd0);
            if (pop) begin
                armed <= 1'b1;
            end
            if (advance) begin
                m_valid    <= skid_valid || pending;
                skid_valid <= skid_valid && pending;
            end else begin
                skid_valid <= skid_valid || pending;
            end
        end
    end

    // Output word: the skid word is older than the returning RAM word.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data <= '0;
        end else if (out_load) begin
            m_data <= skid_valid ? skid_data : ram_dout;
        end
    end

    // Skid word: parks returning RAM data while m_data is still held.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_data <= ram_dout;
        end
    end

`ifdef SDPB_FIFO_LEVEL_EN
    assign level     = bcnt;
    assign need_data = bcnt <= 10'd256;
`endif

endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// Testbench for sdpb_fifo_ctrl: RAM model, byte-queue reference model with a
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_sdpb_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        flush;
    logic        underrun;
    logic        ram_cea;
    logic        ram_ceb;
    logic        ram_oce;
    logic [8:0]  ram_ada;
    logic [7:0]  ram_din;
    logic [6:0]  ram_adb;
    logic [31:0] ram_dout;
`ifdef SDPB_FIFO_LEVEL_EN
    logic [9:0]  level;
    logic        need_data;
`endif

    sdpb_fifo_ctrl dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .underrun(underrun),
        .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_oce(ram_oce),
        .ram_ada(ram_ada), .ram_din(ram_din), .ram_adb(ram_adb),
        .ram_dout(ram_dout)
`ifdef SDPB_FIFO_LEVEL_EN
        , .level(level), .need_data(need_data)
`endif
    );

    always #5 clk = ~clk;

    // RAM: byte-wide write port, word-wide read port, one-cycle read latency.
    logic [7:0]  mem [512];
    logic [31:0] dout_q;
    assign ram_dout = dout_q;
    always @(posedge clk) begin
        if (ram_cea) mem[ram_ada] <= ram_din;
        if (ram_ceb) dout_q <= {mem[{ram_adb, 2'd3}], mem[{ram_adb, 2'd2}],
                                mem[{ram_adb, 2'd1}], mem[{ram_adb, 2'd0}]};
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes written and not yet popped, in order.
    logic [7:0] q[$];
    int wcnt = 0;
    int rcnt = 0;
    int outstanding = 0;
    bit armed = 0;
    int stall = 0;
    int npop = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    // Compare process: inputs are stable at the falling edge, so the model
    // checks outputs here and then advances as the next rising edge will.
    always @(negedge clk) begin
        logic exp_ready, wr, pop;
        logic [31:0] word;
        exp_ready = !reset && !flush && (q.size() < 512);
        wr  = s_valid && exp_ready;
        pop = m_valid && m_ready && !reset && !flush;

        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("ram_cea", 32'(ram_cea), 32'(wr));
        chk("ram_oce", 32'(ram_oce), 32'd1);
        chk("underrun", 32'(underrun), 32'(armed && m_ready && !m_valid && !flush && !reset));
        if (wr) begin
            chk("ram_ada", 32'(ram_ada), 32'(wcnt));
            chk("ram_din", 32'(ram_din), 32'(s_data));
        end
        if (reset || flush) chk("ceb_idle", 32'(ram_ceb), 32'd0);
        if (ram_ceb) begin
            chk("ram_adb", 32'(ram_adb), 32'(rcnt));
            chk("issue_safe", 32'((outstanding + 1) * 4 <= q.size()), 32'd1);
        end
        if (m_valid) chk("valid_backed", 32'(outstanding >= 1), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", m_data, prev_data);
        end
`ifdef SDPB_FIFO_LEVEL_EN
        chk("level", 32'(level), 32'(q.size()));
        chk("need_data", 32'(need_data), 32'(q.size() <= 256));
`endif
        if (!reset && !flush && !m_valid && q.size() >= 4) stall++;
        else stall = 0;
        chk("stall", 32'(stall > 3), 32'd0);

        if (pop) begin
            if (q.size() >= 4) word = {q[3], q[2], q[1], q[0]};
            else word = 32'hxxxxxxxx;
            chk("pop_data", m_data, word);
        end

        prev_hold = m_valid && !m_ready && !reset && !flush;
        prev_data = m_data;

        if (reset || flush) begin
            q.delete();
            wcnt = 0; rcnt = 0; outstanding = 0; armed = 0;
        end else begin
            if (wr) begin
                q.push_back(s_data);
                wcnt = (wcnt + 1) % 512;
            end
            if (pop) begin
                repeat (4) if (q.size() > 0) void'(q.pop_front());
                outstanding--;
                armed = 1;
                npop++;
            end
            if (ram_ceb) begin
                outstanding++;
                rcnt = (rcnt + 1) % 128;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b27 [4];
        int n;
        int j;
        b27[0] = 8'h11; b27[1] = 8'h22; b27[2] = 8'h33; b27[3] = 8'h44;
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_ceb", 32'(ram_ceb), 32'd0);

        // Four bytes, consumer stalled: word appears two edges after the 4th.
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = b27[i];
            tick();
        end
        s_valid = 1'b0;
        chk("lat_n0", 32'(m_valid), 32'd0);
        tick();
        chk("lat_n1", 32'(m_valid), 32'd0);
        tick();
        chk("lat_n2", 32'(m_valid), 32'd1);
        chk("first_word", m_data, 32'h44332211);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // Starvation after a pop pulses every cycle; a flush disarms it.
        m_ready = 1'b1;
        n = 0;
        repeat (3) begin #2; if (underrun) n++; tick(); end
        chk("underrun_armed", 32'(n), 32'd3);
        m_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; m_ready = 1'b1;
        n = 0;
        repeat (3) begin #2; if (underrun) n++; tick(); end
        chk("underrun_disarmed", 32'(n), 32'd0);
        m_ready = 1'b0;

        // Fill all 512 bytes with the consumer stalled.
        for (int i = 0; i < 512; i++) begin
            s_valid = 1'b1; s_data = 8'(i) ^ 8'h5A;
            tick();
        end
        s_data = 8'hEE;
        #1;
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_no_write", 32'(ram_cea), 32'd0);
        tick();
        s_valid = 1'b0;
        chk("full_s_ready2", 32'(s_ready), 32'd0);
        chk("full_head", m_data, 32'h59585B5A);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("ready_after_pop", 32'(s_ready), 32'd1);
        chk("second_word_valid", 32'(m_valid), 32'd1);
        chk("second_word", m_data, 32'h5D5C5F5E);

        // Streaming with m_ready held: one word per clock across the rptr wrap.
        m_ready = 1'b1; s_valid = 1'b1;
        j = 512; n = 0;
        s_data = 8'(j) ^ 8'h5A;
        repeat (150) begin
            #2; if (m_valid) n++;
            tick();
            j++;
            s_data = 8'(j) ^ 8'h5A;
        end
        chk("stream_rate", 32'(n), 32'd150);
        m_ready = 1'b0; s_valid = 1'b0;

        // Write and pop in the same cycle at 8 bytes: net -3.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
        tick();
        s_valid = 1'b0; m_ready = 1'b0;
        chk("net_minus3_model", 32'(q.size()), 32'd5);
`ifdef SDPB_FIFO_LEVEL_EN
        chk("net_minus3_level", 32'(level), 32'd5);
`endif

        // Flush while a read is in flight: nothing stale may appear.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 8'hC0 + 8'(i);
            tick();
            if (i == 3) chk("issue_after_4th", 32'(ram_ceb), 32'd1);
        end
        flush = 1'b1; s_valid = 1'b1; s_data = 8'hC5; m_ready = 1'b1;
        tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_model_empty", 32'(q.size()), 32'd0);
`ifdef SDPB_FIFO_LEVEL_EN
        chk("flush_level", 32'(level), 32'd0);
`endif
        repeat (4) begin
            tick();
            chk("no_stale", 32'(m_valid), 32'd0);
        end

        // Randomized traffic with alternating fill/drain bias.
        npop = 0;
        for (int c = 0; c < 4000; c++) begin
            bit fill;
            fill = ((c / 300) % 2) == 0;
            s_valid = fill ? ($urandom % 8 != 0) : ($urandom % 3 == 0);
            s_data  = 8'($urandom);
            m_ready = fill ? ($urandom % 4 == 0) : ($urandom % 5 != 0);
            flush   = ($urandom % 250 == 0);
            reset   = ($urandom % 1200 == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        tick();
        chk("rand_pops", 32'(npop > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
